zeta_rom_seq: RTL and testbench
===============================

# zeta_rom_seq

Parametrised constant-table ROM with a built-in address sequencer for the Kyber NTT/INTT datapath. It streams a programmable run of table entries (forward or reverse order, optionally negated mod Q) over a valid/ready interface, with full throughput under backpressure. It also provides an independent single-cycle random-access read port. It replaces the fixed 7-bit/12-bit registered lookup tables that the butterfly controller currently indexes by hand.

## Interface
- DATA_WIDTH, 12, entry width
- ADDR_WIDTH, 7, address width
- DEPTH, 128, number of entries (≤ 2**ADDR_WIDTH)
- Q, 3329, modulus used for negation
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch a run; sampled only in IDLE
- base  in  ADDR_WIDTH  first address of the run
- count  in  ADDR_WIDTH+1  number of entries, 0..DEPTH
- reverse  in  1  1 = decrement address, 0 = increment
- negate  in  1  1 = output (Q - v) for v≠0, 0 stays 0
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the last beat is accepted
- out_valid  out  1  stream beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  DATA_WIDTH  table value, after negation
- out_addr  out  ADDR_WIDTH  address the beat came from
- out_last  out  1  final beat of the run
- ra_en  in  1  random-access read request
- ra_addr  in  ADDR_WIDTH  random-access address
- ra_data  out  DATA_WIDTH  registered read data, never negated
- ra_valid  out  1  ra_en delayed by one cycle

## Operation
- Table: entry i = 17^brv7(i) mod 3329, i.e. 1, 1729, 2580, 3289, 2642, 630, 1897, 848, ...
- Addresses ≥ DEPTH read as 0.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: start=1 latches base/count/reverse/negate and asserts busy. Goes to ISSUE, or to DRAIN if count=0.
  - ISSUE: issues one address per cycle while the output buffer has space. Address steps ±1 modulo 2**ADDR_WIDTH; 0-1 wraps to 2**ADDR_WIDTH-1, and 127+1 wraps to 0. After count issues, goes to DRAIN.
  - DRAIN: waits for the buffer to empty and the last beat to be accepted. Then pulses done, drops busy and returns to IDLE.
- Output buffer: 2-entry skid FIFO after the registered ROM read. An address is issued only if (occupancy + in-flight reads) < 2.
- A beat transfers when out_valid && out_ready. out_data/out_addr/out_last hold while out_valid && !out_ready.
- out_last is set on beat number count.
- start while busy is ignored; there is no queueing.
- The random-access port is independent of the stream, with no arbitration. It is a second read path of the same table.
- Negation: out = (v==0) ? 0 : Q - v, computed in DATA_WIDTH bits before the buffer.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_addr=0, out_last=0, ra_data=0, ra_valid=0. FSM=IDLE, buffer empty.
- start accepted at edge T: busy=1 after T; first address issued in cycle T+1; out_valid=1 after edge T+2.
- With out_ready held high: one beat per cycle, and the last beat is visible after edge T+1+count.
- done pulses in the cycle after the edge at which the last beat transfers, with busy=0 in that same cycle.
- count=0: busy for one cycle, done pulses after T+1, no beats.
- ra_en at edge T: ra_data/ra_valid valid after edge T+1.
- rst_n low mid-run: asynchronous clear to reset values; in-flight beats are discarded and there is no done pulse.

## Structure
- Shared package kyber_pkg: Q, DATA_WIDTH, ADDR_WIDTH defaults, FSM state enum, brv7 function, table-init function.
- One sub-module, zeta_rom: dual-read-port registered ROM (read latency 1) holding the table.
- Sequencer, negation and skid FIFO live in the top level.

## Test plan
- Forward run: base=0, count=4, negate=0, ready=1 -> beats 1, 1729, 2580, 3289 on addresses 0..3; out_last on beat 4; done one cycle later.
- Reverse with wrap: base=1, count=3, reverse=1 -> addresses 1, 0, 127; data 1729, 1, entry127; out_last on the third beat.
- Negated run: base=0, count=2, negate=1 -> 3328, 1600; a zero entry (address ≥ DEPTH with DEPTH<128) -> 0.
- Backpressure: count=8 with out_ready toggling every cycle -> all 8 values in order with none lost or duplicated; outputs stable while stalled; no address issued while buffer occupancy plus in-flight reads equals 2.
- Edge cases: count=0 -> done with no beats; start during busy -> ignored; count=128 -> all 128 entries.
- Random access and reset: ra_addr=7 during a stream -> ra_data=848 one cycle later, stream unaffected; rst_n pulse mid-run -> all outputs 0, FSM IDLE, no done.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, sequencer state encoding and the zeta table generator.
// Entry i of the table is 17^brv7(i) mod Q.
package kyber_pkg;

  localparam int KYBER_Q          = 3329;
  localparam int KYBER_DATA_WIDTH = 12;
  localparam int KYBER_ADDR_WIDTH = 7;
  localparam int KYBER_DEPTH      = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  function automatic logic [6:0] brv7(input logic [6:0] a);
    logic [6:0] r;
    for (int b = 0; b < 7; b++) r[b] = a[6-b];
    return r;
  endfunction

  // Elaboration-time only: used to build the ROM contents.
  function automatic logic [11:0] zeta_entry(input int idx);
    int e;
    int acc;
    e   = int'(brv7(idx[6:0]));
    acc = 1;
    for (int k = 0; k < e; k++) acc = (acc * 17) % KYBER_Q;
    return acc[11:0];
  endfunction

endpackage

// File: rtl/zeta_rom.sv
// Dual-read-port zeta table, registered outputs (read latency 1).
// Addresses at or above DEPTH read as zero.
module zeta_rom
  import kyber_pkg::*;
#(
  parameter int DATA_WIDTH = KYBER_DATA_WIDTH,
  parameter int ADDR_WIDTH = KYBER_ADDR_WIDTH,
  parameter int DEPTH      = KYBER_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_data
);

  localparam int SIZE = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rom [SIZE];

  for (genvar i = 0; i < SIZE; i++) begin : g_rom
    if (i < DEPTH) begin : g_entry
      localparam logic [11:0] ENTRY = zeta_entry(i);
      assign rom[i] = DATA_WIDTH'(ENTRY);
    end else begin : g_pad
      assign rom[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data <= '0;
      b_data <= '0;
    end else begin
      if (a_en) a_data <= rom[a_addr];
      if (b_en) b_data <= rom[b_addr];
    end
  end

endmodule

// File: rtl/zeta_rom_seq.sv
// Zeta ROM with run sequencer, optional mod-Q negation and 2-entry skid FIFO,
// plus an independent random-access read port.
//   state    | meaning
//   ST_IDLE  | waiting for start; run parameters latched on start
//   ST_ISSUE | one ROM address per cycle while the FIFO has room
//   ST_DRAIN | all addresses issued; wait for last beat to be accepted
module zeta_rom_seq
  import kyber_pkg::*;
#(
  parameter int DATA_WIDTH = KYBER_DATA_WIDTH,
  parameter int ADDR_WIDTH = KYBER_ADDR_WIDTH,
  parameter int DEPTH      = KYBER_DEPTH,
  parameter int Q          = KYBER_Q
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  reverse,
  input  logic                  negate,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  input  logic                  ra_en,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  output logic                  ra_valid
);

  seq_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
  logic [ADDR_WIDTH:0]   remain, remain_nxt;
  logic                  rev, rev_nxt;
  logic                  neg, neg_nxt;
  logic                  done_nxt;
  logic                  issue, issue_last;

  logic                  rd_valid, rd_last;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rom_data, beat_data;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [ADDR_WIDTH-1:0] fifo_addr [2];
  logic                  fifo_last [2];
  logic [1:0]            occ;
  logic                  wr_ptr, rd_ptr;
  logic                  push, pop, space;
  logic [2:0]            fill;

  zeta_rom #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .a_en  (issue),
    .a_addr(cur_addr),
    .a_data(rom_data),
    .b_en  (ra_en),
    .b_addr(ra_addr),
    .b_data(ra_data)
  );

  assign push = rd_valid;
  assign pop  = out_valid && out_ready;
  // Credit counts the beat leaving this cycle so a steady stream keeps full rate.
  assign fill  = 3'(occ) + 3'(rd_valid) - 3'(pop);
  assign space = fill < 3'd2;

  assign busy      = (state != ST_IDLE);
  assign out_valid = (occ != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_addr  = fifo_addr[rd_ptr];
  assign out_last  = fifo_last[rd_ptr];

  assign beat_data = (neg && rom_data != '0) ? DATA_WIDTH'(Q) - rom_data : rom_data;

  always_comb begin
    state_nxt    = state;
    cur_addr_nxt = cur_addr;
    remain_nxt   = remain;
    rev_nxt      = rev;
    neg_nxt      = neg;
    done_nxt     = 1'b0;
    issue        = 1'b0;
    issue_last   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cur_addr_nxt = base;
          remain_nxt   = count;
          rev_nxt      = reverse;
          neg_nxt      = negate;
          state_nxt    = (count == '0) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (space) begin
          issue        = 1'b1;
          issue_last   = (remain == (ADDR_WIDTH+1)'(1));
          cur_addr_nxt = rev ? cur_addr - ADDR_WIDTH'(1) : cur_addr + ADDR_WIDTH'(1);
          remain_nxt   = remain - (ADDR_WIDTH+1)'(1);
          if (issue_last) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Empty-pipe exit only happens for a zero-length run.
        if ((pop && out_last) || (occ == 2'd0 && !rd_valid)) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_addr <= '0;
      remain   <= '0;
      rev      <= 1'b0;
      neg      <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_addr  <= '0;
      ra_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cur_addr <= cur_addr_nxt;
      remain   <= remain_nxt;
      rev      <= rev_nxt;
      neg      <= neg_nxt;
      done     <= done_nxt;
      rd_valid <= issue;
      ra_valid <= ra_en;
      if (issue) begin
        rd_addr <= cur_addr;
        rd_last <= issue_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= beat_data;
        fifo_addr[wr_ptr] <= rd_addr;
        fifo_last[wr_ptr] <= rd_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_zeta_rom_seq.sv
// Scoreboard bench for zeta_rom_seq: randomized runs and random-access reads
// checked against a table computed from 17^brv7(i) mod 3329.
module tb_zeta_rom_seq;

  localparam int TB_DEPTH = 120;
  localparam int QM       = 3329;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  base = '0;
  logic [7:0]  count = '0;
  logic        reverse = 1'b0;
  logic        negate = 1'b0;
  logic        busy, done, out_valid, out_last, ra_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data, ra_data;
  logic [6:0]  out_addr;
  logic        ra_en = 1'b0;
  logic [6:0]  ra_addr = '0;

  zeta_rom_seq #(.DEPTH(TB_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .count(count),
    .reverse(reverse), .negate(negate), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .ra_en(ra_en), .ra_addr(ra_addr),
    .ra_data(ra_data), .ra_valid(ra_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int addr; bit last; } beat_t;
  typedef struct { int data; int due; } ra_t;

  beat_t exp_q[$];
  ra_t   ra_q[$];
  int    model_tbl[128];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    t_start = 0;
  int    run_count = 0;
  int    ready_mode = 0;
  bit    full_rate = 0, first_pending = 0, done_due = 0, zero_done_ok = 0;
  bit    ra_active = 0, force7 = 0;
  bit    prev_stall = 0;
  int    prev_data, prev_addr, prev_last;

  function automatic int brv(input int i);
    int r = 0;
    int x = i;
    for (int b = 0; b < 7; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic int pow17(input int e);
    int acc = 1;
    for (int k = 0; k < e; k++) acc = (acc * 17) % QM;
    return acc;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(posedge clk) begin
    ra_t r;
    #1;
    ra_en = 1'b0;
    if (force7) begin
      ra_en = 1'b1; ra_addr = 7'd7;
      r.data = 848; r.due = cyc + 1; ra_q.push_back(r);
      force7 = 0;
    end else if (ra_active && $urandom_range(0, 2) == 0) begin
      ra_en = 1'b1; ra_addr = 7'($urandom_range(0, 127));
      r.data = model_tbl[int'(ra_addr)]; r.due = cyc + 1; ra_q.push_back(r);
    end
  end

  always @(negedge clk) begin
    beat_t e;
    bit    exp_rv;
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), prev_data);
        chk("stall_addr", int'(out_addr), prev_addr);
        chk("stall_last", int'(out_last), prev_last);
      end
      if (first_pending && out_valid) begin
        chk("first_beat_latency", cyc - t_start, 2);
        first_pending = 0;
      end
      if (done_due) begin
        chk("done_pulse", int'(done), 1);
        chk("done_busy_low", int'(busy), 0);
        done_due = 0;
      end else if (done && !zero_done_ok) begin
        chk("unexpected_done", int'(done), 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_addr", int'(out_addr), -1);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", int'(out_data), e.data);
          chk("beat_addr", int'(out_addr), e.addr);
          chk("beat_last", int'(out_last), int'(e.last));
          if (e.last) begin
            done_due = 1;
            if (full_rate) chk("last_beat_latency", cyc - t_start, 1 + run_count);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = int'(out_data);
      prev_addr  = int'(out_addr);
      prev_last  = int'(out_last);
      exp_rv = (ra_q.size() != 0) && (ra_q[0].due == cyc);
      if (ra_valid || exp_rv) begin
        chk("ra_valid", int'(ra_valid), int'(exp_rv));
        if (exp_rv) chk("ra_data", int'(ra_data), ra_q.pop_front().data);
      end
    end
  end

  task automatic launch(input int b, input int c, input bit rv, input bit ng, input int rmode);
    beat_t e;
    int    a;
    ready_mode = rmode;
    @(posedge clk); #1;
    start = 1'b1; base = 7'(b); count = 8'(c); reverse = rv; negate = ng;
    for (int k = 0; k < c; k++) begin
      a = rv ? (((b - k) % 128) + 128) % 128 : (b + k) % 128;
      e.addr = a;
      e.data = (ng && model_tbl[a] != 0) ? QM - model_tbl[a] : model_tbl[a];
      e.last = (k == c - 1);
      exp_q.push_back(e);
    end
    first_pending = (c > 0);
    run_count     = c;
    full_rate     = (rmode == 0);
    @(posedge clk); #1;
    start = 1'b0;
    t_start = cyc;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0 || done_due) && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) chk("run_timeout_pending_beats", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int b, input int c, input bit rv, input bit ng, input int rmode);
    launch(b, c, rv, ng, rmode);
    wait_idle(c * 6 + 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) model_tbl[i] = (i < TB_DEPTH) ? pow17(brv(i)) : 0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_addr", int'(out_addr), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_ra_data", int'(ra_data), 0);
    chk("rst_ra_valid", int'(ra_valid), 0);

    // Directed cases from the plan, with literal anchors on the first beats.
    run(0, 4, 0, 0, 0);
    chk("anchor_entry1", model_tbl[1] + model_tbl[2] * 0, 1729);
    run(1, 3, 1, 0, 0);
    run(0, 2, 0, 1, 0);
    run(126, 4, 0, 1, 0);
    run(5, 8, 0, 0, 1);

    // Zero-length run: one busy cycle, then done with no beats.
    zero_done_ok = 1;
    launch(9, 0, 0, 0, 0);
    @(negedge clk);
    chk("zero_busy_first_cycle", int'(busy), 1);
    chk("zero_no_done_yet", int'(done), 0);
    @(negedge clk);
    chk("zero_done", int'(done), 1);
    chk("zero_busy_low", int'(busy), 0);
    chk("zero_no_beat", int'(out_valid), 0);
    @(negedge clk);
    zero_done_ok = 0;

    // Start pulse while busy must be dropped entirely.
    launch(20, 10, 0, 0, 2);
    repeat (3) @(posedge clk);
    #1; start = 1'b1; base = 7'd50; count = 8'd5;
    @(posedge clk); #1; start = 1'b0;
    wait_idle(100);
    repeat (6) @(negedge clk);
    chk("no_queued_start_busy", int'(busy), 0);

    // Full table under random backpressure, random reads in the background.
    ra_active = 1;
    force7 = 1;
    run(0, 128, 0, 0, 2);
    force7 = 1;
    run(64, 128, 1, 1, 0);

    for (int r = 0; r < 12; r++)
      run($urandom_range(0, 127), $urandom_range(1, 24), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 2));

    // Asynchronous reset in the middle of a run.
    ra_active = 0;
    repeat (4) @(posedge clk);
    launch(30, 20, 0, 0, 2);
    repeat (6) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", int'(out_data), 0);
    chk("midrst_out_addr", int'(out_addr), 0);
    chk("midrst_out_last", int'(out_last), 0);
    chk("midrst_done", int'(done), 0);
    exp_q.delete();
    ra_q.delete();
    first_pending = 0; done_due = 0; prev_stall = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_done_low", int'(done), 0);
      chk("post_rst_idle", int'(busy) + int'(out_valid), 0);
    end
    run(2, 4, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
